// File: rtl/uart_pkg.sv
// Shared constants and types for the UART core.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_W     = 12;
  localparam int UART_MIN_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  typedef logic [UART_DIV_W-1:0] uart_div_t;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for asynchronous inputs; flops reset to RESET_VAL so an
// idle-high line reads idle straight out of reset.
module uart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(d_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, finds the start edge,
// samples each bit at its midpoint and presents the byte with a done strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int DIV_W       = UART_DIV_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx_din_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_done,
  output logic                 rx_ing,
  output logic                 rx_err
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(UART_MIN_DIV);

  logic                 line;
  logic                 line_prev_q, line_prev_d;
  uart_rx_state_t       state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_ing_q, rx_ing_d;
  logic                 rx_err_q, rx_err_d;

  logic [DIV_W-1:0]     half_div;
  logic [DIV_W-1:0]     div_m1;
  logic                 fall_edge;

  uart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_din_i),
    .q_o   (line)
  );

  assign half_div  = div_q >> 1;
  assign div_m1    = div_q - 1'b1;
  // Only a real 1->0 transition starts a frame; a stuck-low line never does.
  assign fall_edge = line_prev_q & ~line;

  always_comb begin
    line_prev_d = line;
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    rx_err_d    = 1'b0;
    rx_ing_d    = rx_ing_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall_edge) begin
          state_d  = START;
          div_d    = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
          rx_ing_d = 1'b1;
        end
      end
      START: begin
        if (cnt_q == half_div) begin
          cnt_d = '0;
          if (!line) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d  = IDLE;
            rx_ing_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (cnt_q == div_m1) begin
          cnt_d            = '0;
          shreg_d[bit_idx_q] = line;
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Byte is delivered even when the stop bit reads 0.
        if (cnt_q == div_m1) begin
          cnt_d     = '0;
          state_d   = IDLE;
          rx_data_d = shreg_q;
          rx_done_d = 1'b1;
          rx_err_d  = ~line;
          rx_ing_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_prev_q <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      rx_ing_q    <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      line_prev_q <= line_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      rx_ing_q    <= rx_ing_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign rx_data_o = rx_data_q;
  assign rx_done   = rx_done_q;
  assign rx_ing    = rx_ing_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; frames are described as bytes
// and bit periods, expected results come from a queue of sent frames.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] baud_div = 12'd87;
  logic        rx_din = 1'b1;
  logic [7:0]  rx_data_o;
  logic        rx_done;
  logic        rx_ing;
  logic        rx_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int push_cnt = 0;
  int ing_run = 0;
  int last_ing_len = 0;
  logic [7:0] model_data = 8'h00;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .baud_div  (baud_div),
    .rx_din_i  (rx_din),
    .rx_data_o (rx_data_o),
    .rx_done   (rx_done),
    .rx_ing    (rx_ing),
    .rx_err    (rx_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Monitor: scoreboard against the queue of sent frames.
  always @(posedge clk) begin
    logic [8:0] exp;
    #1;
    if (reset) begin
      model_data = 8'h00;
      ing_run    = 0;
      check("reset_outputs", 32'({rx_done, rx_ing, rx_err, rx_data_o}), 32'h0);
    end else begin
      if (rx_done) begin
        done_cnt++;
        check("done_vs_sent", 32'(done_cnt <= push_cnt), 32'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("rx_data", 32'(rx_data_o), 32'(exp[7:0]));
          check("rx_err", 32'(rx_err), 32'(exp[8]));
          model_data = exp[7:0];
        end
      end else begin
        check("err_without_done", 32'(rx_err), 32'd0);
      end
      check("rx_data_hold", 32'(rx_data_o), 32'(model_data));
      if (rx_ing) begin
        ing_run++;
      end else if (ing_run != 0) begin
        last_ing_len = ing_run;
        ing_run      = 0;
      end
    end
  end

  task automatic drive_bits(input logic v, input int cycles);
    rx_din = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int period,
                            input int chg_bit, input logic [11:0] chg_div);
    exp_q.push_back({~stop, data});
    push_cnt++;
    drive_bits(1'b0, period);
    for (int i = 0; i < 8; i++) begin
      drive_bits(data[i], period);
      if (i == chg_bit) baud_div = chg_div;
    end
    drive_bits(stop, period);
  endtask

  task automatic send(input logic [7:0] data, input int period);
    send_frame(data, 1'b1, period, -1, 12'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int div;
    int eff;
    logic [7:0] b;
    logic [7:0] r;
    logic       stop;

    @(negedge clk);
    repeat (3) @(negedge clk);
    check("reset_rx_ing", 32'(rx_ing), 32'd0);
    check("reset_rx_data", 32'(rx_data_o), 32'd0);
    reset = 1'b0;
    drive_bits(1'b1, 10);

    // Clean frame at 87 clocks per bit
    baud_div = 12'd87;
    d0 = done_cnt;
    send(8'hA5, 87);
    drive_bits(1'b1, 2 * 87);
    check("clean_done_count", 32'(done_cnt - d0), 32'd1);
    check("clean_data", 32'(rx_data_o), 32'hA5);
    check("clean_ing_len", 32'(iabs(2 * last_ing_len - 19 * 87) <= 6), 32'd1);

    // Framing error, then line held low for 20 bit times
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 87, -1, 12'd0);
    drive_bits(1'b0, 20 * 87);
    check("ferr_done_count", 32'(done_cnt - d0), 32'd1);
    check("ferr_data", 32'(rx_data_o), 32'h3C);
    drive_bits(1'b1, 3 * 87);
    check("ferr_no_more_done", 32'(done_cnt - d0), 32'd1);

    // Start-bit glitch
    d0 = done_cnt;
    drive_bits(1'b0, 20);
    drive_bits(1'b1, 3 * 87);
    check("glitch_done_count", 32'(done_cnt - d0), 32'd0);
    check("glitch_ing_len", 32'(iabs(2 * last_ing_len - 87) <= 6), 32'd1);
    check("glitch_ing_low", 32'(rx_ing), 32'd0);

    // Back-to-back frames, no idle gap
    baud_div = 12'd16;
    d0 = done_cnt;
    send(8'h00, 16);
    send(8'hFF, 16);
    send(8'h55, 16);
    drive_bits(1'b1, 2 * 16);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd3);
    check("b2b_last_data", 32'(rx_data_o), 32'h55);

    // Reset during data bit 4 of 0xF0
    d0 = done_cnt;
    b = 8'hF0;
    drive_bits(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bits(b[i], 16);
    drive_bits(b[4], 8);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rx_ing", 32'(rx_ing), 32'd0);
    check("midreset_rx_data", 32'(rx_data_o), 32'd0);
    reset = 1'b0;
    drive_bits(1'b1, 8 * 16);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    send(8'h81, 16);
    drive_bits(1'b1, 2 * 16);
    check("after_reset_done", 32'(done_cnt - d0), 32'd1);
    check("after_reset_data", 32'(rx_data_o), 32'h81);

    // Divisor changed mid-frame is ignored
    baud_div = 12'd16;
    d0 = done_cnt;
    send_frame(8'h6B, 1'b1, 16, 2, 12'd87);
    drive_bits(1'b1, 2 * 16);
    check("divlatch_done", 32'(done_cnt - d0), 32'd1);
    check("divlatch_data", 32'(rx_data_o), 32'h6B);

    // Divisors below the minimum behave as the minimum
    d0 = done_cnt;
    baud_div = 12'd2;
    send(8'hC3, 4);
    drive_bits(1'b1, 8);
    baud_div = 12'($urandom_range(0, 3));
    r = 8'($urandom);
    send(r, 4);
    drive_bits(1'b1, 8);
    check("mindiv_done", 32'(done_cnt - d0), 32'd2);
    check("mindiv_data", 32'(rx_data_o), 32'(r));

    // Randomized frames
    for (int n = 0; n < 8; n++) begin
      div  = $urandom_range(0, 40);
      eff  = (div < 4) ? 4 : div;
      r    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      baud_div = 12'(div);
      d0 = done_cnt;
      send_frame(r, stop, eff, -1, 12'd0);
      drive_bits(1'b1, 2 * eff);
      check("rand_done", 32'(done_cnt - d0), 32'd1);
      check("rand_data", 32'(rx_data_o), 32'(r));
    end

    drive_bits(1'b1, 20);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
